// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Final stage of the argon CPU. Buffers LSU load results in a small
//            FIFO, arbitrates ALU vs. FIFO head round-robin, and issues one
//            registered write per cycle to the register file. Keeps a count of
//            retired writes (rd != 0) for debug/performance monitoring.
// Macro    : WB_FWD_EN - when defined, o_fwd_* mirror the registered write
//            port so decode can bypass the value being written this cycle;
//            when undefined, o_fwd_* are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
  parameter int LSU_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  input  logic        i_alu_valid,
  output logic        o_alu_ready,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,

  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_data,

  output logic        o_write_en,
  output logic [4:0]  o_selectW,
  output logic [31:0] o_portW,
  output logic [31:0] o_wb_count,

  output logic        o_fwd_valid,
  output logic [4:0]  o_fwd_rd,
  output logic [31:0] o_fwd_data
);

  // Pointer width; LSU_DEPTH is a power of two of at least 2, so pointers
  // wrap modulo the depth purely by overflowing.
  localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE    = 1;
  localparam logic [PTR_W:0]   OCC_ONE    = 1;
  localparam logic [PTR_W:0]   OCC_ZERO   = 0;
  localparam logic [PTR_W:0]   FULL_COUNT = LSU_DEPTH[PTR_W:0];
  localparam logic [31:0]      COUNT_ONE  = 32'd1;

  // Encoding of the round-robin history flag.
  localparam logic GRANT_LSU = 1'b0;
  localparam logic GRANT_ALU = 1'b1;

  // --------------------------------------------------------------------------
  // LSU result FIFO state
  // --------------------------------------------------------------------------
  logic [4:0]       fifo_rd   [LSU_DEPTH];
  logic [31:0]      fifo_data [LSU_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   occupancy;
  logic [PTR_W:0]   occupancy_next;
  logic             lsu_ready;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // --------------------------------------------------------------------------
  // Arbiter and write port state
  // --------------------------------------------------------------------------
  logic             last_grant;
  logic             contested;
  logic             grant_alu;
  logic             grant_lsu;
  logic [4:0]       win_rd;
  logic [31:0]      win_data;

  logic             write_en;
  logic [4:0]       select_w;
  logic [31:0]      port_w;
  logic [31:0]      wb_count;

  // --------------------------------------------------------------------------
  // FIFO handshakes. Ready is a registered copy of "not full" so it depends
  // only on occupancy and never on a same-cycle pop.
  // --------------------------------------------------------------------------
  assign fifo_empty = (occupancy == OCC_ZERO);
  assign push       = i_lsu_valid && lsu_ready;
  assign pop        = grant_lsu;

  // Occupancy after this edge: a simultaneous push and pop cancel out.
  always_comb begin
    occupancy_next = occupancy;
    case ({push, pop})
      2'b10:   occupancy_next = occupancy + OCC_ONE;
      2'b01:   occupancy_next = occupancy - OCC_ONE;
      default: occupancy_next = occupancy;
    endcase
  end

  // FIFO storage: entries are only meaningful while counted in occupancy,
  // so the array itself needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= i_lsu_rd;
      fifo_data[wr_ptr] <= i_lsu_data;
    end
  end

  // FIFO pointers, occupancy and the registered not-full flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= OCC_ZERO;
      lsu_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      occupancy <= occupancy_next;
      lsu_ready <= (occupancy_next != FULL_COUNT);
    end
  end

  assign o_lsu_ready = lsu_ready;

  // --------------------------------------------------------------------------
  // Round-robin arbitration between the ALU and the FIFO head. With a single
  // candidate it simply wins; on contention the source that did not win the
  // previous contest is chosen.
  // --------------------------------------------------------------------------
  assign contested = i_alu_valid && !fifo_empty;
  assign grant_alu = i_alu_valid && (fifo_empty || (last_grant == GRANT_LSU));
  assign grant_lsu = !fifo_empty && !grant_alu;

  // The ALU may only see ready while out of reset, even if it is valid.
  assign o_alu_ready = grant_alu && i_reset_n;

  // Select the winning result for the write register.
  always_comb begin
    win_rd   = fifo_rd[rd_ptr];
    win_data = fifo_data[rd_ptr];
    if (grant_alu) begin
      win_rd   = i_alu_rd;
      win_data = i_alu_data;
    end
  end

  // Round-robin history: only a contested grant changes who goes next.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      last_grant <= GRANT_LSU;
    end else if (contested) begin
      last_grant <= grant_alu ? GRANT_ALU : GRANT_LSU;
    end
  end

  // --------------------------------------------------------------------------
  // Registered register-file write port. Writes to x0 are consumed but never
  // strobed; idle cycles keep the last index/data on the bus.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      write_en <= 1'b0;
      select_w <= '0;
      port_w   <= '0;
    end else if (grant_alu || grant_lsu) begin
      write_en <= (win_rd != 5'd0);
      select_w <= win_rd;
      port_w   <= win_data;
    end else begin
      write_en <= 1'b0;
    end
  end

  assign o_write_en = write_en;
  assign o_selectW  = select_w;
  assign o_portW    = port_w;

  // Retired-write counter: one per strobed write, wrapping naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wb_count <= '0;
    end else if (write_en) begin
      wb_count <= wb_count + COUNT_ONE;
    end
  end

  assign o_wb_count = wb_count;

  // --------------------------------------------------------------------------
  // Forwarding tap toward decode.
  // --------------------------------------------------------------------------
`ifdef WB_FWD_EN
  assign o_fwd_valid = write_en;
  assign o_fwd_rd    = select_w;
  assign o_fwd_data  = port_w;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_rd    = 5'd0;
  assign o_fwd_data  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Directed, self-checking bench for writeback_stage. A queue-based
//            reference model predicts every output each cycle; directed
//            steps additionally pin hand-computed literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        write_en;
  logic [4:0]  select_w;
  logic [31:0] port_w;
  logic [31:0] wb_count;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  always #5 clk = ~clk;

  writeback_stage #(.LSU_DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_alu_valid(alu_valid),
    .o_alu_ready(alu_ready),
    .i_alu_rd   (alu_rd),
    .i_alu_data (alu_data),
    .i_lsu_valid(lsu_valid),
    .o_lsu_ready(lsu_ready),
    .i_lsu_rd   (lsu_rd),
    .i_lsu_data (lsu_data),
    .o_write_en (write_en),
    .o_selectW  (select_w),
    .o_portW    (port_w),
    .o_wb_count (wb_count),
    .o_fwd_valid(fwd_valid),
    .o_fwd_rd   (fwd_rd),
    .o_fwd_data (fwd_data)
  );

  // --------------------------------------------------------------------------
  // Reference model state
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  bit          m_last_alu = 1'b0;   // 1: ALU won the most recent contest
  bit          m_we       = 1'b0;
  logic [4:0]  m_sel      = '0;
  logic [31:0] m_port     = '0;
  logic [31:0] m_cnt      = '0;
  bit          m_lsu_rdy  = 1'b1;
  bit          m_alu_fire = 1'b0;

  bit          preset   = 1'b0;     // counter was forced to all-ones this cycle
  bit          check_on = 1'b0;
  int          aidx     = 0;

  // Literal pins for the current cycle
  logic [6:0]  pin_mask = '0;
  logic        pin_we;
  logic [4:0]  pin_sel;
  logic [31:0] pin_port;
  logic [31:0] pin_cnt;
  logic        pin_lrdy;
  logic        pin_ardy;
  logic [4:0]  pin_frd;

  int checks = 0;
  int errors = 0;

  // Reference model: evaluates the arbitration and FIFO rules at each edge.
  initial begin
    entry_t e;
    bit     alu_c, lsu_c, take_alu, take_lsu, do_push;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        q.delete();
        m_last_alu = 1'b0;
        m_we       = 1'b0;
        m_sel      = '0;
        m_port     = '0;
        m_cnt      = '0;
        m_lsu_rdy  = 1'b1;
        m_alu_fire = 1'b0;
      end else begin
        m_cnt    = (preset ? 32'hFFFF_FFFF : m_cnt) + (m_we ? 32'd1 : 32'd0);
        alu_c    = alu_valid;
        lsu_c    = (q.size() > 0);
        take_alu = alu_c && (!lsu_c || !m_last_alu);
        take_lsu = lsu_c && !take_alu;
        do_push  = lsu_valid && m_lsu_rdy;
        if (alu_c && lsu_c) m_last_alu = take_alu;
        m_alu_fire = take_alu;
        if (take_alu) begin
          m_we   = (alu_rd != 5'd0);
          m_sel  = alu_rd;
          m_port = alu_data;
        end else if (take_lsu) begin
          e      = q.pop_front();
          m_we   = (e.rd != 5'd0);
          m_sel  = e.rd;
          m_port = e.data;
        end else begin
          m_we = 1'b0;
        end
        if (do_push) q.push_back('{rd: lsu_rd, data: lsu_data});
        m_lsu_rdy = (q.size() < DEPTH);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: all DUT outputs against the model, plus any literal pins.
  initial begin
    bit exp_ardy;
    forever begin
      @(negedge clk);
      if (check_on) begin
        exp_ardy = reset_n && alu_valid && ((q.size() == 0) || !m_last_alu);
        chk("alu_ready", 32'(alu_ready), 32'(exp_ardy));
        chk("lsu_ready", 32'(lsu_ready), 32'(m_lsu_rdy));
        chk("write_en",  32'(write_en),  32'(m_we));
        chk("selectW",   32'(select_w),  32'(m_sel));
        chk("portW",     port_w,         m_port);
        chk("wb_count",  wb_count,       m_cnt);
`ifdef WB_FWD_EN
        chk("fwd_valid", 32'(fwd_valid), 32'(m_we));
        chk("fwd_rd",    32'(fwd_rd),    32'(m_sel));
        chk("fwd_data",  fwd_data,       m_port);
`else
        chk("fwd_valid", 32'(fwd_valid), 32'd0);
        chk("fwd_rd",    32'(fwd_rd),    32'd0);
        chk("fwd_data",  fwd_data,       32'd0);
`endif
        if (pin_mask[0]) chk("pin_write_en",  32'(write_en),  32'(pin_we));
        if (pin_mask[1]) chk("pin_selectW",   32'(select_w),  32'(pin_sel));
        if (pin_mask[2]) chk("pin_portW",     port_w,         pin_port);
        if (pin_mask[3]) chk("pin_wb_count",  wb_count,       pin_cnt);
        if (pin_mask[4]) chk("pin_lsu_ready", 32'(lsu_ready), 32'(pin_lrdy));
        if (pin_mask[5]) chk("pin_alu_ready", 32'(alu_ready), 32'(pin_ardy));
        if (pin_mask[6]) chk("pin_fwd_rd",    32'(fwd_rd),    32'(pin_frd));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = 32'hA000_0000 | {27'd0, lrd};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pin_mask = '0;
    if (m_alu_fire) aidx++;
  endtask

  task automatic pin_out(input bit we, input logic [4:0] sel, input logic [31:0] port,
                         input logic [31:0] cnt);
    pin_we = we; pin_sel = sel; pin_port = port; pin_cnt = cnt;
    pin_mask[3:0] = 4'hF;
  endtask

  task automatic pin_we_only(input bit we);
    pin_we = we; pin_mask[0] = 1'b1;
  endtask

  task automatic pin_count(input logic [31:0] cnt);
    pin_cnt = cnt; pin_mask[3] = 1'b1;
  endtask

  task automatic pin_lsu(input bit rdy);
    pin_lrdy = rdy; pin_mask[4] = 1'b1;
  endtask

  task automatic pin_alu(input bit rdy);
    pin_ardy = rdy; pin_mask[5] = 1'b1;
  endtask

  task automatic pin_fwd(input logic [4:0] rd);
    pin_frd = rd; pin_mask[6] = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    reset_n = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    step();
    // Reset state, with the ALU valid: ready must stay low during reset
    check_on = 1'b1;
    pin_out(1'b0, 5'd0, 32'd0, 32'd0);
    pin_lsu(1'b1);
    pin_alu(1'b0);
    step();

    // ALU single write
    reset_n = 1'b1;
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    pin_alu(1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    pin_out(1'b1, 5'd5, 32'hDEAD_BEEF, 32'd0);
    step();
    pin_out(1'b0, 5'd5, 32'hDEAD_BEEF, 32'd1);
    step();

    // Destination x0: consumed, never strobed, counter untouched
    drive(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0);
    pin_alu(1'b1);
    pin_count(32'd1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    pin_out(1'b0, 5'd0, 32'h1234_5678, 32'd1);
    step();
    pin_count(32'd1);
    step();

    // FIFO fill with ALU contention: writes go 7,1,7,2,7,3,7,4,5,6
    aidx = 0;
    for (int c = 0; c < 13; c++) begin
      drive((c >= 1) && (aidx < 4), 5'd7, 32'h7000 + 32'(aidx), c <= 5, 5'(c + 1));
      case (c)
        2:  pin_out(1'b1, 5'd7, 32'h0000_7000, 32'd1);
        3:  pin_out(1'b1, 5'd1, 32'hA000_0001, 32'd2);
        6:  begin pin_lsu(1'b0); pin_out(1'b1, 5'd7, 32'h0000_7002, 32'd5); end
        9:  pin_out(1'b1, 5'd4, 32'hA000_0004, 32'd8);
        12: pin_out(1'b0, 5'd6, 32'hA000_0006, 32'd11);
        default: ;
      endcase
      step();
    end

    // Hold three entries, then push and pop together with the ALU idle
    aidx = 0;
    for (int d = 0; d < 14; d++) begin
      drive(d <= 4, 5'd0, 32'h5000 + 32'(aidx), d <= 6, 5'(10 + d));
      case (d)
        5:  pin_lsu(1'b1);
        6:  begin pin_lsu(1'b1); pin_we_only(1'b1); pin_sel = 5'd12; pin_mask[1] = 1'b1; end
        7:  begin pin_lsu(1'b1); pin_sel = 5'd13; pin_mask[1] = 1'b1; end
        default: ;
      endcase
      step();
    end

    // Reset mid-operation with LSU entries queued
    aidx = 0;
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 5'd20, 32'h2000 + 32'(aidx), 1'b1, 5'(21 + r));
      step();
    end
    reset_n = 1'b0;
    drive(1'b1, 5'd20, 32'h2000 + 32'(aidx), 1'b0, 5'd0);
    pin_alu(1'b0);
    step();
    reset_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    pin_out(1'b0, 5'd0, 32'd0, 32'd0);
    pin_lsu(1'b1);
    step();
    for (int i = 0; i < 4; i++) begin
      pin_we_only(1'b0);
      pin_count(32'd0);
      step();
    end

    // Counter wrap: preload all-ones, then one write to x9
    @(negedge clk);
    #1;
    force dut.wb_count = 32'hFFFF_FFFF;
    preset = 1'b1;
    #1;
    release dut.wb_count;
    @(posedge clk);
    #1;
    preset   = 1'b0;
    pin_mask = '0;
    drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0);
    pin_count(32'hFFFF_FFFF);
    pin_alu(1'b1);
    step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    pin_out(1'b1, 5'd9, 32'h9999_0009, 32'hFFFF_FFFF);
`ifdef WB_FWD_EN
    pin_fwd(5'd9);
`else
    pin_fwd(5'd0);
`endif
    step();
    pin_out(1'b0, 5'd9, 32'h9999_0009, 32'd0);
    step();
    step();

    check_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
